// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, entry layout and helpers
package pipe_pkg;
    localparam logic [31:0] NOP_INST = 32'h2000_0000;
    localparam int BP_OFF = 0;
    localparam int BP_W = 1;
    localparam int INST_OFF = BP_OFF + BP_W;
    function automatic int pc_off(input int xlen);
        return INST_OFF + xlen;
    endfunction
    function automatic int entry_w(input int xlen, input int pc_bits);
        return pc_off(xlen) + pc_bits;
    endfunction
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo_ptr.sv
// sync_fifo_ptr: generic FIFO pointer/occupancy controller with flush
module sync_fifo_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = clog2(DEPTH),
    parameter int CW = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] wr_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // pointers wrap naturally; flush behaves like reset and drops same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
        end
    end
    a_count_range: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH) && !(pop && empty) && !(push && full));
endmodule

// File: rtl/f_to_d_queue.sv
// f_to_d_queue: fetch-to-decode FIFO with flush and NOP bubble when empty
module f_to_d_queue
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_BITS = 5,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] NOP = XLEN'(NOP_INST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       F_valid,
    input  logic [PC_BITS-1:0]         F_pc,
    input  logic [XLEN-1:0]            F_inst,
    input  logic                       F_BP_taken,
    output logic                       F_ready,
    input  logic                       stall_D,
    input  logic                       EX_taken,
    output logic                       D_valid,
    output logic [PC_BITS-1:0]         D_pc,
    output logic [XLEN-1:0]            D_inst,
    output logic                       D_BP_taken,
    output logic [$clog2(DEPTH+1)-1:0] D_count
);
    localparam int AW = clog2(DEPTH);
    localparam int EW = entry_w(XLEN, PC_BITS);
    localparam int PC_OFF = pc_off(XLEN);
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic push, pop, full, empty;
    assign push = F_valid && F_ready;
    assign pop = D_valid && !stall_D;
    assign F_ready = !full;
    assign D_valid = !empty;
    sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(EX_taken),
        .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .count(D_count), .full(full), .empty(empty)
    );
    // storage needs no reset: an entry is only visible once counted
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {F_pc, F_inst, F_BP_taken};
    end
    assign head = mem[rd_ptr];
    assign D_pc = D_valid ? head[PC_OFF +: PC_BITS] : '0;
    assign D_inst = D_valid ? head[INST_OFF +: XLEN] : NOP;
    assign D_BP_taken = D_valid && head[BP_OFF];
endmodule

// File: doc/f_to_d_queue.md
Name: f_to_d_queue

Overview:
Parametrised fetch-to-decode decoupling stage that replaces the single-entry F/D pipeline register with a DEPTH-entry FIFO. Each entry holds {pc, inst, bp_taken}. Fetch pushes with a valid/ready handshake, and decode pops unless stalled. A taken branch in EX flushes every entry. When the queue is empty, decode sees a NOP bubble.

Parameters:
XLEN, 32, instruction width
PC_BITS, 5, PC width
DEPTH, 4, number of entries; power of 2, at least 2
NOP, 32'h2000_0000, bubble instruction presented when empty (addi r0 r0 0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
F_valid  in  1  fetch presents an instruction this cycle
F_pc  in  PC_BITS  fetched PC
F_inst  in  XLEN  fetched instruction
F_BP_taken  in  1  predictor said taken
F_ready  out  1  queue can accept a push (not full)
stall_D  in  1  decode cannot consume this cycle
EX_taken  in  1  redirect; flush the queue
D_valid  out  1  head entry is valid
D_pc  out  PC_BITS  head PC, or 0 when empty
D_inst  out  XLEN  head instruction, or NOP when empty
D_BP_taken  out  1  head prediction bit, or 0 when empty
D_count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- State: storage array[DEPTH], rd_ptr and wr_ptr (each $clog2(DEPTH) bits), count register. Pointers wrap modulo DEPTH by natural overflow.
- Push condition: push = F_valid && F_ready.
- Pop condition: pop = D_valid && !stall_D.
- F_ready = (count != DEPTH). Combinational from count only; no dependency on stall_D or pop, so there is no full-bypass.
- D_valid = (count != 0).
- D_pc, D_inst and D_BP_taken read array[rd_ptr] when D_valid is 1. Otherwise they are 0, NOP and 0.
- Latency: an entry pushed at edge N is visible on the D_* ports after edge N if the queue was empty. This matches the old single-register timing.
- Count update:
  - push and pop in the same cycle: count unchanged, both pointers advance.
  - push only: count+1.
  - pop only: count-1.
- Flush on EX_taken at an edge:
  - rd_ptr, wr_ptr and count go to 0.
  - A same-cycle push is discarded, and so is a same-cycle pop.
  - After that edge, D_valid=0 and D_inst=NOP.
- Priority: rst > EX_taken > normal push/pop.
- Reset: pointers and count go to 0, so after reset D_valid=0, D_pc=0, D_inst=NOP, D_BP_taken=0, F_ready=1, D_count=0. Array contents need no reset; they are never observable while count is 0.
- Full with stall_D=1: F_ready=0, any F_valid is ignored, and the head stays stable.
- Full with stall_D=0: the pop happens and F_ready stays 0 this cycle. F_ready becomes 1 on the next cycle.
- Empty with stall_D=0: no pop, and the outputs remain a bubble.
- Stall with a non-empty queue: the D_* outputs hold exactly, and pushes continue until the queue is full.
- Reset asserted mid-operation: the next edge clears the queue regardless of the other inputs.
- Assertion (sim only): count never exceeds DEPTH and never underflows.

Decomposition:
- Shared package pipe_pkg holds:
  - the NOP constant;
  - the f_to_d entry layout as localparam field offsets/widths (pc, inst, bp_taken);
  - the helper clog2.
- Natural sub-module: sync_fifo_ptr, a generic pointer/count controller (push, pop, flush → rd_ptr, wr_ptr, count, full, empty). It is reusable for later D/EX queues.
- The storage array and output muxing stay in f_to_d_queue.

Test Plan:
- Reset: hold rst for 2 cycles with F_valid=1. Required: D_valid=0, D_inst=32'h2000_0000, D_pc=0, F_ready=1, D_count=0.
- Streaming: push pc=1..6 back-to-back with stall_D=0. Required: D_pc shows 1,2,...,6 in consecutive cycles, each one cycle after its push; D_count stays at 1.
- Fill and backpressure: stall_D=1 while pushing pc=1..5. Required: F_ready falls after the 4th push; pc=5 is not accepted; D_count=4; D_pc holds 1. Then release the stall: D_pc reads 1,2,3,4, and F_ready returns one cycle after the first pop.
- Flush: with 3 entries queued, assert EX_taken together with F_valid=1, pc=9. Required: the next cycle shows D_valid=0, D_inst=NOP, D_count=0, and pc=9 is never output.
- Pointer wrap: 10 push/pop pairs with varying stalls and DEPTH=4, checked against a scoreboard. Required: exact in-order pc/inst/bp_taken with no loss or duplication.
- Reset priority: assert rst and EX_taken together while the queue is full. Required: reset values on the next cycle.
